// File: rtl/ifu_axi_pkg.sv
// Shared types for the instruction fetch AXI4-Lite front end: FSM state encoding,
// AXI response codes and a debug helper that turns a state into printable ASCII.
package ifu_axi_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_AR   = 2'd1,
        IFU_R    = 2'd2,
        IFU_RESP = 2'd3
    } ifu_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Four ASCII characters per state, handy for waveform viewers and bench messages.
    function automatic logic [31:0] state_name(input ifu_state_t s);
        logic [31:0] name;
        case (s)
            IFU_IDLE: name = "IDLE";
            IFU_AR:   name = "AR  ";
            IFU_R:    name = "R   ";
            IFU_RESP: name = "RESP";
            default:  name = "????";
        endcase
        return name;
    endfunction

endpackage

// File: rtl/ifu_axi_if.sv
// Fetch-request and AXI4-Lite read bundle; master is the fetch unit, slave is the
// controller/memory side that issues requests and answers AR/R.
interface ifu_axi_if #(
    parameter int XLEN = 32
);
    logic            reqValid;
    logic [XLEN-1:0] pc;
    logic            respValid;
    logic [XLEN-1:0] inst;
    logic            fault;

    logic            arvalid;
    logic            arready;
    logic [XLEN-1:0] araddr;
    logic            rvalid;
    logic            rready;
    logic [XLEN-1:0] rdata;
    logic [1:0]      rresp;

    modport master (
        input  reqValid, pc, arready, rvalid, rdata, rresp,
        output respValid, inst, fault, arvalid, araddr, rready
    );

    modport slave (
        output reqValid, pc, arready, rvalid, rdata, rresp,
        input  respValid, inst, fault, arvalid, araddr, rready
    );

endinterface

// File: rtl/ifu_axi.sv
// Single-outstanding instruction fetch over AXI4-Lite; misaligned pc faults with no bus access.
// respValid 3 cycles after reqValid (2 when misaligned); AR and R simply wait on arready/rvalid.
module ifu_axi
    import ifu_axi_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] FAULT_INST = XLEN'(32'h0000_0013)
) (
    input logic       clock,
    input logic       reset,
    ifu_axi_if.master bus
);

    ifu_state_t      state;
    ifu_state_t      state_nxt;
    logic            misalign_pend;
    logic            misalign_pend_nxt;
    logic            capture;
    logic            pc_aligned;
    logic            beat_take;

    logic            arvalid_q;
    logic            rready_q;
    logic            resp_q;
    logic [XLEN-1:0] araddr_q;
    logic [XLEN-1:0] inst_q;
    logic            fault_q;

    assign pc_aligned = (bus.pc[1:0] == 2'b00);

    always_comb begin
        state_nxt         = state;
        misalign_pend_nxt = 1'b0;
        capture           = 1'b0;
        beat_take         = 1'b0;
        case (state)
            IFU_IDLE: begin
                // A misaligned request spends one decode cycle in IDLE before RESP.
                if (misalign_pend) begin
                    state_nxt = IFU_RESP;
                end else if (bus.reqValid) begin
                    if (pc_aligned) begin
                        capture   = 1'b1;
                        state_nxt = IFU_AR;
                    end else begin
                        misalign_pend_nxt = 1'b1;
                    end
                end
            end
            IFU_AR: begin
                if (bus.arready) begin
                    state_nxt = IFU_R;
                end
            end
            IFU_R: begin
                if (bus.rvalid) begin
                    beat_take = 1'b1;
                    state_nxt = IFU_RESP;
                end
            end
            IFU_RESP: begin
                state_nxt = IFU_IDLE;
            end
            default: begin
                state_nxt = IFU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IFU_IDLE;
            misalign_pend <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            resp_q        <= 1'b0;
            araddr_q      <= '0;
            inst_q        <= FAULT_INST;
            fault_q       <= 1'b0;
        end else begin
            state         <= state_nxt;
            misalign_pend <= misalign_pend_nxt;
            // Handshake outputs follow the next state so nothing combinational reaches a port.
            arvalid_q     <= (state_nxt == IFU_AR);
            rready_q      <= (state_nxt == IFU_IDLE) || (state_nxt == IFU_R);
            resp_q        <= (state_nxt == IFU_RESP);
            if (capture) begin
                araddr_q <= bus.pc;
            end
            if (misalign_pend && (state == IFU_IDLE)) begin
                inst_q  <= FAULT_INST;
                fault_q <= 1'b1;
            end else if (beat_take) begin
                if (bus.rresp == AXI_RESP_OKAY) begin
                    inst_q  <= bus.rdata;
                    fault_q <= 1'b0;
                end else begin
                    inst_q  <= FAULT_INST;
                    fault_q <= 1'b1;
                end
            end
        end
    end

    assign bus.arvalid   = arvalid_q;
    assign bus.araddr    = araddr_q;
    assign bus.rready    = rready_q;
    assign bus.respValid = resp_q;
    assign bus.inst      = inst_q;
    assign bus.fault     = fault_q;

endmodule

// File: doc/ifu_axi.md
IFU_AXI -- requirements
Module: ifu_axi

Interface
REQ-001 Parameter XLEN, default 32, data/address width in bits.
REQ-002 Parameter FAULT_INST, default 32'h0000_0013, value driven on inst after any fault.
REQ-003 clock  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 reqValid  input  1  fetch request from the control state machine; sampled only in IDLE.
REQ-006 pc  input  XLEN  fetch address; captured with reqValid in IDLE.
REQ-007 respValid  output  1  one-cycle pulse: inst/fault valid.
REQ-008 inst  output  XLEN  fetched instruction, held until next respValid.
REQ-009 fault  output  1  access fault for the last response, held with inst.
REQ-010 arvalid / arready / araddr  output / input / output  1 / 1 / XLEN  AXI4-Lite read-address channel.
REQ-011 rvalid / rready / rdata / rresp  input / output / input / input  1 / 1 / XLEN / 2  AXI4-Lite read-data channel.

Function
REQ-012 FSM states SHALL be IDLE, AR, R, RESP; all outputs registered or decoded from state only, no input-to-output combinational paths except none.
REQ-013 IDLE + reqValid + pc[1:0]==0: latch pc into araddr, go AR next cycle.
REQ-014 IDLE + reqValid + pc[1:0]!=0: no bus transaction; go RESP with inst=FAULT_INST, fault=1.
REQ-015 AR: arvalid=1, araddr stable; arvalid&&arready at cycle A moves to R at A+1; arvalid SHALL NOT drop before handshake.
REQ-016 R: rready=1; rvalid at cycle B captures inst=rdata, fault=0 if rresp==2'b00, else inst=FAULT_INST, fault=1; go RESP at B+1.
REQ-017 RESP: respValid=1 for exactly one cycle, then IDLE.
REQ-018 Minimum latency with arready and rvalid tied high: reqValid at cycle T -> respValid at T+3.
REQ-019 reqValid in AR, R or RESP SHALL be ignored (controller holds it high while waiting); no second request is queued.
REQ-020 At most one read outstanding on the bus at any time.
REQ-021 IDLE + rvalid (stale beat): rready=1, beat discarded, inst/fault/respValid unchanged.
REQ-022 inst and fault SHALL change only on the transition into RESP.
REQ-023 araddr SHALL be XLEN bits of the latched pc; pc changes after capture SHALL NOT affect araddr.

Reset
REQ-024 reset SHALL force state=IDLE, arvalid=0, rready=0, respValid=0, fault=0, inst=FAULT_INST, araddr=0 at the next rising edge.
REQ-025 reset mid-AR or mid-R SHALL abandon the transaction; a late rvalid is handled per REQ-021.
REQ-026 reset asserted together with reqValid: reset wins; no request is captured.

Structure
REQ-027 Shared package SHALL hold the FSM state enum (IFU_IDLE, IFU_AR, IFU_R, IFU_RESP) and AXI_RESP_OKAY/SLVERR/DECERR constants.
REQ-028 Single flat module; no sub-module is required.
REQ-029 Implementation SHALL be 120-400 lines including debug state-name decode.

Verification
REQ-030 pc=0x8000_0000, arready=1, rvalid same cycle as rready, rdata=0x0010_0073, rresp=0 -> araddr=0x8000_0000, respValid pulse at T+3, inst=0x0010_0073, fault=0.
REQ-031 arready held low 5 cycles, then high; rvalid delayed 4 cycles -> arvalid/araddr stable throughout, single respValid, reqValid kept high is ignored, exactly one AR handshake.
REQ-032 pc=0x8000_0002 -> no arvalid, respValid at T+2, inst=0x0000_0013, fault=1.
REQ-033 rresp=2'b10, rdata=0xDEAD_BEEF -> inst=0x0000_0013, fault=1, respValid one cycle.
REQ-034 reset asserted during R, then rvalid=1 arrives in IDLE -> rready=1 that cycle, respValid stays 0, inst=0x0000_0013.
REQ-035 Back-to-back requests with reqValid the cycle after respValid -> second fetch completes with its own pc; inst holds first value until second respValid.
